// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with per-byte write enables, self-clearing after reset,
// configurable read latency (1 or 2) and same-address read-during-write policy.
module ram_sdp_be #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned RDW_NEW = 1,
  localparam int unsigned NB     = WIDTH / 8,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NB-1:0]    wr_be,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             clear_we, wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] pipe_data;
  logic             pipe_vld;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      // Counter parks at the last address instead of wrapping.
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clear_we = (state_q == StInit) && !rst;
  assign wr_acc   = (state_q == StRun) && !rst && wr_en;
  assign rd_acc   = (state_q == StRun) && !rst && rd_en;

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_addr];
    // Forward enabled write bytes when the policy asks for the new data.
    if ((RDW_NEW != 0) && wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  if (RD_LAT >= 2) begin : g_lat2
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data_q <= '0;
        s1_vld_q  <= 1'b0;
      end else begin
        s1_vld_q <= rd_acc;
        if (rd_acc) s1_data_q <= rd_word;
      end
    end

    assign pipe_data = s1_data_q;
    assign pipe_vld  = s1_vld_q;
  end else begin : g_lat1
    assign pipe_data = rd_word;
    assign pipe_vld  = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pipe_vld;
      if (pipe_vld) rd_data_q <= pipe_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = (state_q == StRun);

endmodule

// File: tb/tb_ram_sdp_be.sv
// Scoreboard bench: two instances (RD_LAT=1/new-data and RD_LAT=2/old-data) share stimulus;
// a reference memory model predicts each read and its arrival edge.
module tb_ram_sdp_be;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [3:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          init_done_a, init_done_b;

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  exp_t         q_a[$], q_b[$];
  logic [W-1:0] mdl_mem [D];
  logic         mdl_run = 1'b0;
  int           mdl_cnt = 0;
  logic [W-1:0] last_a = '0, last_b = '0;

  always #5 clk = ~clk;

  ram_sdp_be #(.WIDTH(W), .DEPTH(D), .RD_LAT(1), .RDW_NEW(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .init_done(init_done_a)
  );

  ram_sdp_be #(.WIDTH(W), .DEPTH(D), .RD_LAT(2), .RDW_NEW(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .init_done(init_done_b)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [3:0] be);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Reference model, evaluated on each rising edge with the inputs as sampled there.
  initial begin
    logic [W-1:0] old_w, new_w;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        q_a.delete();
        q_b.delete();
        last_a  = '0;
        last_b  = '0;
        mdl_run = 1'b0;
        mdl_cnt = 0;
      end else if (!mdl_run) begin
        mdl_mem[mdl_cnt] = '0;
        if (mdl_cnt == D - 1) mdl_run = 1'b1;
        else mdl_cnt++;
      end else begin
        if (rd_en) begin
          old_w = mdl_mem[rd_addr];
          new_w = (wr_en && wr_addr == rd_addr) ? merge(old_w, wr_data, wr_be) : old_w;
          q_a.push_back('{data: new_w, due: edge_n});
          q_b.push_back('{data: old_w, due: edge_n + 1});
        end
        if (wr_en) mdl_mem[wr_addr] = merge(mdl_mem[wr_addr], wr_data, wr_be);
      end
    end
  end

  // Output monitor on the falling edge.
  initial begin
    logic ev;
    exp_t e;
    forever begin
      @(negedge clk);
      check_eq("init_done_a", W'(init_done_a), W'(mdl_run));
      check_eq("init_done_b", W'(init_done_b), W'(mdl_run));

      while (q_a.size() > 0 && q_a[0].due < edge_n) void'(q_a.pop_front());
      ev = (q_a.size() > 0) && (q_a[0].due == edge_n);
      check_eq("rd_valid_a", W'(rd_valid_a), W'(ev));
      if (ev) begin
        e = q_a.pop_front();
        last_a = e.data;
      end
      check_eq("rd_data_a", rd_data_a, last_a);

      while (q_b.size() > 0 && q_b[0].due < edge_n) void'(q_b.pop_front());
      ev = (q_b.size() > 0) && (q_b[0].due == edge_n);
      check_eq("rd_valid_b", W'(rd_valid_b), W'(ev));
      if (ev) begin
        e = q_b.pop_front();
        last_b = e.data;
      end
      check_eq("rd_data_b", rd_data_b, last_b);
    end
  end

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [3:0] be,
                       input logic re, input logic [AW-1:0] ra);
    rst     = r;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] be);
    drive(1'b0, 1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0, '0, 1'b1, '0);
    drive(1'b1, 1'b1, 4'd1, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'd1);
    // Requests during clear must be ignored.
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, AW'(i), 32'hCAFE_0000 + i, 4'hF, 1'b1, AW'(i));
    for (int i = 0; i < D; i++) rd(AW'(i));
    idle(3);

    wr(4'd5, 32'hAABB_CCDD, 4'b1111);
    wr(4'd5, 32'h1122_3344, 4'b0101);
    rd(4'd5);
    idle(3);

    wr(4'd3, 32'h0102_0304, 4'b1111);
    drive(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'b0011, 1'b1, 4'd3);
    rd(4'd3);
    idle(3);

    wr(4'd0, 32'h1000_0000, 4'hF);
    wr(4'd1, 32'h2000_0001, 4'hF);
    wr(4'd2, 32'h3000_0002, 4'hF);
    rd(4'd0);
    rd(4'd1);
    rd(4'd2);
    idle(3);

    // A write right after an accepted read must not disturb that read.
    rd(4'd7);
    wr(4'd7, 32'h7777_7777, 4'hF);
    rd(4'd7);
    idle(2);

    wr(4'd9, 32'h9999_0009, 4'hF);
    drive(1'b0, 1'b1, 4'd8, 32'h8888_0008, 4'hF, 1'b1, 4'd9);
    rd(4'd8);
    idle(2);
    wr(4'd0, 32'h0, 4'b0000);
    rd(4'd0);
    idle(2);

    for (int i = 0; i < 80; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)));
    end
    idle(3);

    // Reset while a read is in flight.
    wr(4'd4, 32'h5A5A_5A5A, 4'hF);
    idle(1);
    rd(4'd4);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < D + 2; i++) drive(1'b0, 1'b1, 4'd4, 32'h5A5A_5A5A, 4'hF, 1'b1, 4'd4);
    rd(4'd4);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
